// File: rtl/usr_param_burst.sv
// usr_param_burst: parametrised universal shift register with counted shift/rotate bursts.
// Optional parity output PAR (= ^PO) is enabled by defining USR_PARITY_EN.
module usr_param_burst #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] nshift,
    input  logic             sil,
    input  logic             sir,
    input  logic [WIDTH-1:0] pi,
    output logic [WIDTH-1:0] po,
    output logic             sol,
    output logic             sor,
    output logic             busy,
    output logic             done
`ifdef USR_PARITY_EN
    ,
    output logic             par
`endif
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, nsat;
    logic [2:0]       lmode, lmode_d, op_mode;
    logic [WIDTH-1:0] po_d, op_res;
    logic             done_d, burst_mode;

    assign busy       = state == BURST;
    assign sol        = po[WIDTH-1];
    assign sor        = po[0];
    assign nsat       = (nshift > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : nshift;
    assign op_mode    = busy ? lmode : mode;
    assign burst_mode = mode inside {3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
`ifdef USR_PARITY_EN
    assign par        = ^po;
`endif

    // Result of applying the selected operation to the current register value
    always_comb begin
        op_res = po;
        case (op_mode)
            3'b001:  op_res = {po[WIDTH-2:0], sil};
            3'b010:  op_res = {sir, po[WIDTH-1:1]};
            3'b011:  op_res = pi;
            3'b100:  op_res = {po[WIDTH-2:0], po[WIDTH-1]};
            3'b101:  op_res = {po[0], po[WIDTH-1:1]};
            3'b110:  op_res = {po[WIDTH-1], po[WIDTH-1:1]};
            3'b111:  op_res = '0;
            default: op_res = po;
        endcase
    end

    // Next state: burst sequencing has priority, then START, then single-cycle EN
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        lmode_d = lmode;
        po_d    = po;
        done_d  = 1'b0;
        if (busy) begin
            po_d  = op_res;
            cnt_d = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (start && burst_mode) begin
            if (nsat == '0) begin
                done_d = 1'b1;
            end else begin
                state_d = BURST;
                cnt_d   = nsat;
                lmode_d = mode;
            end
        end else if (en) begin
            po_d = op_res;
        end
    end

    // State, register and handshake flops; reset aborts any burst in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            lmode <= 3'b000;
            po    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            lmode <= lmode_d;
            po    <= po_d;
            done  <= done_d;
        end
    end
endmodule

// File: tb/tb_usr_param_burst.sv
// tb_usr_param_burst: directed self-checking bench for usr_param_burst at WIDTH=8.
module tb_usr_param_burst;
    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, start = 1'b0, sil = 1'b0, sir = 1'b0;
    logic [2:0] mode = 3'b000;
    logic [3:0] nshift = 4'd0;
    logic [7:0] pi = 8'h00, po;
    logic       sol, sor, busy, done;
`ifdef USR_PARITY_EN
    logic       par;
`endif
    int checks = 0, failures = 0;

    usr_param_burst #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .mode(mode), .nshift(nshift),
        .sil(sil), .sir(sir), .pi(pi), .po(po), .sol(sol), .sor(sor), .busy(busy), .done(done)
`ifdef USR_PARITY_EN
        , .par(par)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_en(input logic [2:0] m, input logic [7:0] d);
        en = 1'b1; mode = m; pi = d;
        step();
        en = 1'b0;
    endtask

    task automatic test_reset();
        do_en(3'b011, 8'hA5);
        checks++; if (po !== 8'hA5) begin failures++; $display("FAIL pre_reset_load po=%h exp=a5", po); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (po !== 8'h00) begin failures++; $display("FAIL reset_po po=%h exp=00", po); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_flags busy=%b done=%b exp=0/0", busy, done); end
        checks++; if (sol !== 1'b0 || sor !== 1'b0) begin failures++; $display("FAIL reset_serial sol=%b sor=%b exp=0/0", sol, sor); end
`ifdef USR_PARITY_EN
        checks++; if (par !== 1'b0) begin failures++; $display("FAIL reset_par par=%b exp=0", par); end
`endif
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_en_ops();
        do_en(3'b011, 8'hE5);
        checks++; if (po !== 8'hE5) begin failures++; $display("FAIL en_load po=%h exp=e5", po); end
        checks++; if (sol !== 1'b1 || sor !== 1'b1) begin failures++; $display("FAIL serial_out sol=%b sor=%b exp=1/1", sol, sor); end
`ifdef USR_PARITY_EN
        checks++; if (par !== 1'b1) begin failures++; $display("FAIL par_e5 par=%b exp=1", par); end
`endif
        sil = 1'b1;
        do_en(3'b001, 8'h00);
        checks++; if (po !== 8'hCB) begin failures++; $display("FAIL en_sl po=%h exp=cb", po); end
        do_en(3'b011, 8'hE5);
        sir = 1'b0;
        do_en(3'b010, 8'h00);
        checks++; if (po !== 8'h72) begin failures++; $display("FAIL en_sr po=%h exp=72", po); end
        do_en(3'b011, 8'hE5);
        do_en(3'b110, 8'h00);
        checks++; if (po !== 8'hF2) begin failures++; $display("FAIL en_asr po=%h exp=f2", po); end
        do_en(3'b101, 8'h00);
        checks++; if (po !== 8'h79) begin failures++; $display("FAIL en_ror po=%h exp=79", po); end
        do_en(3'b100, 8'h00);
        checks++; if (po !== 8'hF2) begin failures++; $display("FAIL en_rol po=%h exp=f2", po); end
        do_en(3'b000, 8'h00);
        checks++; if (po !== 8'hF2) begin failures++; $display("FAIL en_hold po=%h exp=f2", po); end
        mode = 3'b011; pi = 8'h33;
        step();
        checks++; if (po !== 8'hF2) begin failures++; $display("FAIL no_en po=%h exp=f2", po); end
        do_en(3'b111, 8'h00);
        checks++; if (po !== 8'h00) begin failures++; $display("FAIL en_clear po=%h exp=00", po); end
    endtask

    task automatic test_burst_rol();
        do_en(3'b011, 8'hE5);
        start = 1'b1; mode = 3'b100; nshift = 4'd3;
        step();
        start = 1'b0; en = 1'b1; mode = 3'b011; pi = 8'h00; nshift = 4'd1;
        checks++; if (busy !== 1'b1 || done !== 1'b0 || po !== 8'hE5) begin failures++; $display("FAIL rol_latch busy=%b done=%b po=%h exp=1/0/e5", busy, done, po); end
        step();
        checks++; if (busy !== 1'b1 || done !== 1'b0 || po !== 8'hCB) begin failures++; $display("FAIL rol_1 busy=%b done=%b po=%h exp=1/0/cb", busy, done, po); end
        step();
        checks++; if (busy !== 1'b1 || done !== 1'b0 || po !== 8'h97) begin failures++; $display("FAIL rol_2 busy=%b done=%b po=%h exp=1/0/97", busy, done, po); end
        step();
        en = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b1 || po !== 8'h2F) begin failures++; $display("FAIL rol_3 busy=%b done=%b po=%h exp=0/1/2f", busy, done, po); end
`ifdef USR_PARITY_EN
        checks++; if (par !== 1'b1) begin failures++; $display("FAIL par_2f par=%b exp=1", par); end
`endif
        step();
        checks++; if (done !== 1'b0 || po !== 8'h2F) begin failures++; $display("FAIL rol_after done=%b po=%h exp=0/2f", done, po); end
    endtask

    task automatic test_burst_edges();
        int n;
        start = 1'b1; mode = 3'b010; nshift = 4'd0;
        step();
        start = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || po !== 8'h2F) begin failures++; $display("FAIL zero_len done=%b busy=%b po=%h exp=1/0/2f", done, busy, po); end
        step();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_len_pulse done=%b exp=0", done); end
        start = 1'b1; mode = 3'b011; pi = 8'h00; nshift = 4'd3;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || po !== 8'h2F) begin failures++; $display("FAIL start_load busy=%b done=%b po=%h exp=0/0/2f", busy, done, po); end
        sil = 1'b1; start = 1'b1; mode = 3'b001; nshift = 4'd12;
        step();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++; if (n !== 8) begin failures++; $display("FAIL sat_count shifts=%0d exp=8", n); end
        checks++; if (done !== 1'b1 || po !== 8'hFF) begin failures++; $display("FAIL sat_end done=%b po=%h exp=1/ff", done, po); end
        step();
    endtask

    task automatic test_back_to_back();
        do_en(3'b011, 8'h01);
        start = 1'b1; en = 1'b1; mode = 3'b100; nshift = 4'd2;
        step();
        start = 1'b0; en = 1'b0;
        checks++; if (busy !== 1'b1 || po !== 8'h01) begin failures++; $display("FAIL start_over_en busy=%b po=%h exp=1/01", busy, po); end
        step();
        checks++; if (po !== 8'h02) begin failures++; $display("FAIL b2b_first po=%h exp=02", po); end
        step();
        checks++; if (done !== 1'b1 || busy !== 1'b0 || po !== 8'h04) begin failures++; $display("FAIL b2b_done done=%b busy=%b po=%h exp=1/0/04", done, busy, po); end
        start = 1'b1; mode = 3'b101; nshift = 4'd1;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0 || po !== 8'h04) begin failures++; $display("FAIL b2b_second busy=%b done=%b po=%h exp=1/0/04", busy, done, po); end
        step();
        checks++; if (done !== 1'b1 || busy !== 1'b0 || po !== 8'h02) begin failures++; $display("FAIL b2b_second_done done=%b busy=%b po=%h exp=1/0/02", done, busy, po); end
        step();
    endtask

    task automatic test_reset_mid_burst();
        do_en(3'b011, 8'h81);
        sil = 1'b0; start = 1'b1; mode = 3'b001; nshift = 4'd5;
        step();
        start = 1'b0;
        step();
        step();
        checks++; if (busy !== 1'b1 || po !== 8'h04) begin failures++; $display("FAIL mid_burst busy=%b po=%h exp=1/04", busy, po); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (po !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort po=%h busy=%b done=%b exp=00/0/0", po, busy, done); end
        rst_n = 1'b1;
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_after done=%b busy=%b exp=0/0", done, busy); end
        do_en(3'b011, 8'hE5);
        start = 1'b1; mode = 3'b100; nshift = 4'd1;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL restart_busy busy=%b exp=1", busy); end
        step();
        checks++; if (done !== 1'b1 || po !== 8'hCB) begin failures++; $display("FAIL restart_done done=%b po=%h exp=1/cb", done, po); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_en_ops();
        test_burst_rol();
        test_burst_edges();
        test_back_to_back();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
